// File: rtl/keypad_scan_ctrl.sv
// Tick-paced 4x4 keypad scanner: walks an active-low column, debounces the
// detected key's press and release, and emits one key code strobe per press.
module keypad_scan_ctrl #(
    parameter int unsigned DEBOUNCE_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_TICKS - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] row_m_q, row_s_q;
    logic [1:0] col_idx_q, col_idx_d;
    logic [1:0] row_idx_q, row_idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] col_q, col_d;
    logic [3:0] key_code_q, key_code_d;
    logic       key_valid_q, key_valid_d;
    logic       key_held_q, key_held_d;

    function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
        logic [3:0] k;
        case ({r, c})
            4'b00_00: k = 4'h1;
            4'b00_01: k = 4'h2;
            4'b00_10: k = 4'h3;
            4'b00_11: k = 4'hA;
            4'b01_00: k = 4'h4;
            4'b01_01: k = 4'h5;
            4'b01_10: k = 4'h6;
            4'b01_11: k = 4'hB;
            4'b10_00: k = 4'h7;
            4'b10_01: k = 4'h8;
            4'b10_10: k = 4'h9;
            4'b10_11: k = 4'hC;
            4'b11_00: k = 4'h0;
            4'b11_01: k = 4'hF;
            4'b11_10: k = 4'hE;
            default:  k = 4'hD;
        endcase
        return k;
    endfunction

    // Lowest-numbered low row wins when several keys share the column.
    function automatic logic [1:0] lowest_low(input logic [3:0] r);
        logic [1:0] idx;
        if (!r[0])      idx = 2'd0;
        else if (!r[1]) idx = 2'd1;
        else if (!r[2]) idx = 2'd2;
        else            idx = 2'd3;
        return idx;
    endfunction

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;

        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (row_s_q == 4'hF) begin
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        row_idx_d = lowest_low(row_s_q);
                        cnt_d     = 4'd0;
                        state_d   = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (row_s_q[row_idx_q]) begin
                        state_d   = SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                    end else if (cnt_q == CNT_LAST) begin
                        key_code_d  = key_map(col_idx_q, row_idx_q);
                        key_valid_d = 1'b1;
                        cnt_d       = 4'd0;
                        state_d     = HOLD;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                HOLD: begin
                    if (row_s_q == 4'hF && cnt_q == CNT_LAST) begin
                        state_d   = SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                    end else if (row_s_q == 4'hF) begin
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        cnt_d = 4'd0;
                    end
                end
                default: state_d = SCAN;
            endcase
        end

        col_d      = ~(4'b0001 << col_idx_d);
        key_held_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_m_q     <= 4'hF;
            row_s_q     <= 4'hF;
            state_q     <= SCAN;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            cnt_q       <= 4'd0;
            col_q       <= 4'b1110;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            row_m_q     <= row;
            row_s_q     <= row_m_q;
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: a keypad model drives rows from col,
// and accepted key codes are checked against a queue of expected presses.
module tb_keypad_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [3:0] key_rows [4];
    logic [3:0] exp_q [$];
    int         vectors;
    int         miscompares;
    int         valid_count;

    keypad_scan_ctrl #(.DEBOUNCE_TICKS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Keypad matrix: the driven-low column exposes that column's row pattern.
    always_comb begin
        logic [3:0] sel;
        row = 4'hF;
        for (int i = 0; i < 4; i++) begin
            sel = ~(4'b0001 << i);
            if (col == sel) row = key_rows[i];
        end
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every key_valid pops one expected code.
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            valid_count++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL unexpected_key_valid observed=%h expected=none", key_code);
            end else begin
                chk("key_code_on_valid", key_code, exp_q.pop_front());
            end
        end
    end

    // Three idle clocks for row settle, then a one-cycle tick.
    task automatic do_ticks(input int n);
        repeat (n) begin
            repeat (3) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
        #1;
    endtask

    function automatic logic [3:0] col_of(input int idx);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << idx);
    endfunction

    int vc;

    initial begin
        vectors = 0; miscompares = 0; valid_count = 0;
        for (int i = 0; i < 4; i++) key_rows[i] = 4'hF;
        tick = 1'b0;
        rst  = 1'b1;
        repeat (3) @(negedge clk);

        chk("reset_col", col, 4'b1110);
        chk("reset_key_code", key_code, 4'h0);
        chk("reset_key_valid", {3'b0, key_valid}, 4'h0);
        chk("reset_key_held", {3'b0, key_held}, 4'h0);

        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            do_ticks(1);
            chk($sformatf("idle_col_%0d", k), col, col_of(k % 4));
        end

        // Clean press col2/row1 -> '6'
        vc = valid_count;
        key_rows[2] = 4'b1101;
        exp_q.push_back(4'h6);
        do_ticks(2);
        chk("press6_col_hold", col, 4'b1011);
        do_ticks(2);
        chk("press6_no_early_valid", 4'(valid_count - vc), 4'd0);
        do_ticks(1);
        chk("press6_held", {3'b0, key_held}, 4'h1);
        chk("press6_code", key_code, 4'h6);
        do_ticks(5);
        key_rows[2] = 4'hF;
        do_ticks(2);
        chk("press6_held_release2", {3'b0, key_held}, 4'h1);
        do_ticks(1);
        chk("press6_released", {3'b0, key_held}, 4'h0);
        chk("press6_col_resume", col, 4'b0111);
        chk("press6_one_valid", 4'(valid_count - vc), 4'd1);

        // Bounce in col1
        vc = valid_count;
        do_ticks(2);
        chk("bounce_col1", col, 4'b1101);
        key_rows[1] = 4'b1011;
        do_ticks(1);
        key_rows[1] = 4'hF;
        do_ticks(1);
        chk("bounce_col_adv", col, 4'b1011);
        chk("bounce_no_valid", 4'(valid_count - vc), 4'd0);
        chk("bounce_not_held", {3'b0, key_held}, 4'h0);

        // Long hold of '0' (col0/row3) with a release glitch
        vc = valid_count;
        key_rows[0] = 4'b0111;
        exp_q.push_back(4'h0);
        do_ticks(6);
        chk("long0_code", key_code, 4'h0);
        do_ticks(44);
        chk("long0_held", {3'b0, key_held}, 4'h1);
        chk("long0_one_valid", 4'(valid_count - vc), 4'd1);
        key_rows[0] = 4'hF;
        do_ticks(1);
        key_rows[0] = 4'b0111;
        do_ticks(1);
        key_rows[0] = 4'hF;
        do_ticks(2);
        chk("glitch_still_held", {3'b0, key_held}, 4'h1);
        do_ticks(1);
        chk("glitch_released", {3'b0, key_held}, 4'h0);
        chk("glitch_col_resume", col, 4'b1101);

        // Multi-key col3: rows 0 and 2 low -> 'A', then tick gating
        vc = valid_count;
        key_rows[3] = 4'b1010;
        exp_q.push_back(4'hA);
        do_ticks(6);
        chk("multi_code", key_code, 4'hA);
        repeat (100) @(negedge clk);
        #1;
        chk("gate_col", col, 4'b0111);
        chk("gate_code", key_code, 4'hA);
        chk("gate_held", {3'b0, key_held}, 4'h1);
        chk("gate_valid", {3'b0, key_valid}, 4'h0);
        chk("multi_one_valid", 4'(valid_count - vc), 4'd1);
        key_rows[3] = 4'hF;
        do_ticks(3);
        chk("multi_col_resume", col, 4'b1110);

        // Reset mid-debounce, then a full press of '1'
        vc = valid_count;
        key_rows[0] = 4'b1110;
        do_ticks(3);
        rst = 1'b1;
        #1;
        chk("rst_mid_col", col, 4'b1110);
        chk("rst_mid_code", key_code, 4'h0);
        chk("rst_mid_held", {3'b0, key_held}, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(4'h1);
        do_ticks(4);
        chk("after_rst_code", key_code, 4'h1);
        chk("after_rst_one_valid", 4'(valid_count - vc), 4'd1);
        key_rows[0] = 4'hF;
        do_ticks(3);
        chk("after_rst_col", col, 4'b1101);
        chk("scoreboard_empty", 4'(exp_q.size()), 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
